// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache word requests onto a single-port RAM.
// dcache has priority; a saturating starvation counter lets icache in at a word boundary.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StDAcc, StIAcc} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] starve_q, starve_d;

    logic d_req;
    assign d_req = dREN | dWEN;

    assign dload = ram_load;
    assign iload = ram_load;

    always_comb begin
        state_d   = state_q;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        dwait     = 1'b1;
        iwait     = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (d_req) begin
                    state_d = StDAcc;
                end else if (iREN) begin
                    state_d = StIAcc;
                end
            end
            StDAcc: begin
                if (!d_req) begin
                    state_d = StIdle;
                end else begin
                    ram_ren   = dREN & ~dWEN;
                    ram_wen   = dWEN;
                    ram_addr  = daddr;
                    ram_store = dstore;
                    dwait     = ~ram_ready;
                    // Only a word boundary may hand the RAM to a starved icache.
                    if (ram_ready && iREN && (starve_q >= CntMax)) begin
                        state_d = StIAcc;
                    end
                end
            end
            StIAcc: begin
                if (!iREN) begin
                    state_d = StIdle;
                end else begin
                    ram_ren  = 1'b1;
                    ram_addr = iaddr;
                    iwait    = ~ram_ready;
                    if (ram_ready && d_req) begin
                        state_d = StDAcc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!iREN) begin
            starve_d = '0;
        end else if (state_q == StIAcc) begin
            if (ram_ready) begin
                starve_d = '0;
            end
        end else if (starve_q < CntMax) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven cycle vectors plus a starvation sequence; expectations go through a queue.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dREN, dWEN, iREN, ram_ready;
    logic [31:0] daddr, dstore, iaddr, ram_load;
    logic        dwait, iwait, ram_ren, ram_wen;
    logic [31:0] dload, iload, ram_addr, ram_store;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
    );

    typedef struct {
        logic        chk, rst, dren, dwen, iren, rdy;
        logic [31:0] daddr, dstore, iaddr, rload;
        logic        e_ren, e_wen, e_dwait, e_iwait;
        logic [31:0] e_addr, e_store;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mkv(input logic chk, input logic rst, input logic dren,
                                 input logic dwen, input logic [31:0] da,
                                 input logic [31:0] ds, input logic iren,
                                 input logic [31:0] ia, input logic rdy,
                                 input logic [31:0] rl, input logic e_ren,
                                 input logic e_wen, input logic [31:0] e_addr,
                                 input logic [31:0] e_store, input logic e_dwait,
                                 input logic e_iwait);
        vec_t v;
        v.chk = chk; v.rst = rst; v.dren = dren; v.dwen = dwen; v.iren = iren; v.rdy = rdy;
        v.daddr = da; v.dstore = ds; v.iaddr = ia; v.rload = rl;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr; v.e_store = e_store;
        v.e_dwait = e_dwait; v.e_iwait = e_iwait;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h want 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        RST = v.rst; dREN = v.dren; dWEN = v.dwen; iREN = v.iren; ram_ready = v.rdy;
        daddr = v.daddr; dstore = v.dstore; iaddr = v.iaddr; ram_load = v.rload;
        if (v.chk) sb.push_back(v);
        @(negedge CLK);
        if (v.chk) begin
            e = sb.pop_front();
            check("ram_ren", idx, 32'(ram_ren), 32'(e.e_ren));
            check("ram_wen", idx, 32'(ram_wen), 32'(e.e_wen));
            check("ram_addr", idx, ram_addr, e.e_addr);
            check("ram_store", idx, ram_store, e.e_store);
            check("dwait", idx, 32'(dwait), 32'(e.e_dwait));
            check("iwait", idx, 32'(iwait), 32'(e.e_iwait));
            if (e.e_dwait == 1'b0) check("dload", idx, dload, e.rload);
            if (e.e_iwait == 1'b0) check("iload", idx, iload, e.rload);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic is_i, is_idle;
        // Reset with every input high.
        tbl.push_back(mkv(0, 1, 1, 1, '1, '1, 1, '1, 1, '1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mkv(1, 1, 1, 1, '1, '1, 1, '1, 1, '1, 0, 0, 0, 0, 1, 1));
        // dcache read, ready on the second access cycle.
        tbl.push_back(mkv(1, 0, 1, 0, 32'h40, 0, 1, 32'h80, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mkv(1, 0, 1, 0, 32'h40, 0, 1, 32'h80, 0, 32'hDEADBEEF,
                          1, 0, 32'h40, 0, 1, 1));
        tbl.push_back(mkv(1, 0, 1, 0, 32'h40, 0, 1, 32'h80, 1, 32'hDEADBEEF,
                          1, 0, 32'h40, 0, 0, 1));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
        // Two-word writeback with icache waiting, then icache via IDLE.
        tbl.push_back(mkv(1, 0, 0, 1, 32'h100, 32'hA1, 1, 32'h80, 1, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mkv(1, 0, 0, 1, 32'h100, 32'hA1, 1, 32'h80, 1, 0,
                          0, 1, 32'h100, 32'hA1, 0, 1));
        tbl.push_back(mkv(1, 0, 0, 1, 32'h104, 32'hA2, 1, 32'h80, 1, 0,
                          0, 1, 32'h104, 32'hA2, 0, 1));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 1, 32'h80, 1, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 1, 32'h80, 1, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 1, 32'h80, 1, 32'h55, 1, 0, 32'h80, 0, 1, 0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
        // dREN and dWEN together: write wins.
        tbl.push_back(mkv(1, 0, 1, 1, 32'h200, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mkv(1, 0, 1, 1, 32'h200, 32'h1234, 0, 0, 0, 0,
                          0, 1, 32'h200, 32'h1234, 1, 1));
        // Reset mid-access: no completion afterwards even with ram_ready high.
        tbl.push_back(mkv(1, 1, 1, 1, 32'h200, 32'h1234, 0, 0, 0, 0,
                          0, 1, 32'h200, 32'h1234, 1, 1));
        tbl.push_back(mkv(1, 0, 1, 1, 32'h200, 32'h1234, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Starvation with STARVE_MAX=4: IDLE, four dcache words, icache word, and the
        // counter restarts so the next icache grant comes six cycles later.
        for (int c = 0; c < 12; c++) begin
            vec_t v;
            is_idle = (c == 0);
            is_i    = (c == 5) || (c == 11);
            v = mkv(1, 0, 1, 0, 32'h300, 0, 1, 32'h400, 1, 32'h1000 + 32'(c),
                    !is_idle, 0, is_idle ? 32'h0 : (is_i ? 32'h400 : 32'h300), 0,
                    is_idle || is_i, !is_i);
            step(v, 100 + c);
        end
        step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 112);
        step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 113);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
